// File: rtl/bjk_rom_pkg.sv
// Shared constants and types for the Bomb Jack ROM download path.
package bjk_rom_pkg;

  localparam int unsigned CNT_W  = 17;
  localparam int unsigned NREG   = 6;
  localparam int unsigned ADDR_W = 25;

  // Exact byte count of a valid image.
  localparam logic [CNT_W-1:0] ROM_SIZE = 17'h1C000;

  // Region order defines the bit position in the one-hot region vector.
  typedef enum logic [2:0] {
    RegCpu,
    RegSnd,
    RegChr,
    RegBgt,
    RegSpr,
    RegMap
  } region_e;

  // Ascending region bases; the last region runs up to ROM_SIZE.
  localparam logic [CNT_W-1:0] REGION_BASE [NREG] = '{
    17'h00000, 17'h0A000, 17'h0C000, 17'h0F000, 17'h15000, 17'h1B000
  };

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StDone,
    StError
  } load_state_t;

  // Saturating increment: the byte counter must never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/bjk_rom_loader_if.sv
// ioctl download stream in, decoded region write stream out.
interface bjk_rom_loader_if;
  import bjk_rom_pkg::*;

  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;

  logic [CNT_W-1:0]  dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wr;
  logic [NREG-1:0]   dn_region;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  dn_addr, dn_data, dn_wr, dn_region
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output dn_addr, dn_data, dn_wr, dn_region
  );

endinterface

// File: rtl/bjk_region_decode.sv
// Combinational linear address -> region one-hot plus region-local offset.
module bjk_region_decode
  import bjk_rom_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [NREG-1:0]   region,
  output logic [CNT_W-1:0]  offset
);

  region_e idx;

  // Highest base not above addr wins; bases are ascending.
  always_comb begin
    idx = RegCpu;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (addr >= ADDR_W'(REGION_BASE[i])) begin
        idx = region_e'(i[2:0]);
      end
    end
    region = NREG'(1) << idx;
    offset = addr[CNT_W-1:0] - REGION_BASE[idx];
  end

endmodule

// File: rtl/bjk_rom_loader.sv
// Filters index-0 ioctl downloads, registers decoded writes, counts bytes and
// holds the core in reset until a complete, correctly sized image is loaded.
module bjk_rom_loader
  import bjk_rom_pkg::*;
#(
  parameter logic [CNT_W-1:0] RomSize = ROM_SIZE
) (
  input  logic             clk_sys,
  input  logic             reset,
  bjk_rom_loader_if.slave  bus,
  output logic             rom_ready,
  output logic             load_error,
  output logic             core_reset,
  output logic [15:0]      checksum
);

  load_state_t state_q, state_d;

  logic             download_q;
  logic [CNT_W-1:0] count_q;
  logic [15:0]      checksum_q;
  logic             overflow_q;

  logic             dn_wr_q;
  logic [CNT_W-1:0] dn_addr_q;
  logic [7:0]       dn_data_q;
  logic [NREG-1:0]  dn_region_q;

  logic [NREG-1:0]  dec_region;
  logic [CNT_W-1:0] dec_offset;

  logic dl_rise, dl_fall, start, in_range, accept, drop;

  bjk_region_decode u_decode (
    .addr   (bus.ioctl_addr),
    .region (dec_region),
    .offset (dec_offset)
  );

  assign dl_rise  = bus.ioctl_download & ~download_q;
  assign dl_fall  = ~bus.ioctl_download & download_q;
  assign in_range = bus.ioctl_addr < ADDR_W'(RomSize);
  assign start    = dl_rise & (bus.ioctl_index == 8'd0) &
                    (state_q inside {StIdle, StDone, StError});
  // LOAD still holds in the cycle download falls, so a last byte there counts.
  assign accept   = (state_q == StLoad) & bus.ioctl_wr & in_range;
  assign drop     = (state_q == StLoad) & bus.ioctl_wr & ~in_range;

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StError: if (start) state_d = StLoad;
      StLoad:                  if (dl_fall) state_d = StCheck;
      StCheck: state_d = (count_q == RomSize && !overflow_q) ? StDone : StError;
      default:                 state_d = StIdle;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    rom_ready  = (state_q == StDone);
    load_error = (state_q == StError);
    core_reset = (state_q != StDone);
  end

  // Edge detector, byte counter, checksum, overflow flag and write register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // Track download during reset so a window still open is not seen as new.
      download_q  <= bus.ioctl_download;
      count_q     <= '0;
      checksum_q  <= '0;
      overflow_q  <= 1'b0;
      dn_wr_q     <= 1'b0;
      dn_addr_q   <= '0;
      dn_data_q   <= '0;
      dn_region_q <= '0;
    end else begin
      download_q <= bus.ioctl_download;
      if (start) begin
        count_q    <= '0;
        checksum_q <= '0;
        overflow_q <= 1'b0;
      end else if (accept) begin
        count_q    <= sat_inc(count_q);
        checksum_q <= checksum_q + {8'd0, bus.ioctl_dout};
      end else if (drop) begin
        overflow_q <= 1'b1;
      end
      dn_wr_q     <= accept;
      dn_region_q <= accept ? dec_region : '0;
      if (accept) begin
        dn_addr_q <= dec_offset;
        dn_data_q <= bus.ioctl_dout;
      end
    end
  end

  assign bus.dn_wr     = dn_wr_q;
  assign bus.dn_addr   = dn_addr_q;
  assign bus.dn_data   = dn_data_q;
  assign bus.dn_region = dn_region_q;
  assign checksum      = checksum_q;

endmodule

// File: tb/tb_bjk_rom_loader.sv
// Bench for bjk_rom_loader: a full-size instance for region decode and
// overflow vectors, a reduced-size instance for complete-image load sequences.
module tb_bjk_rom_loader;
  import bjk_rom_pkg::*;

  localparam logic [CNT_W-1:0] SmallSize = 17'h01000;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset;
  logic        dl, wr, sel;
  logic [7:0]  idx, dout;
  logic [24:0] addr;

  logic        rom_ready_f, load_error_f, core_reset_f;
  logic        rom_ready_s, load_error_s, core_reset_s;
  logic [15:0] checksum_f, checksum_s;

  bjk_rom_loader_if bus_f ();
  bjk_rom_loader_if bus_s ();

  // sel=0 steers download/write strobes to the full instance, sel=1 to the small one.
  assign bus_f.ioctl_download = dl & ~sel;
  assign bus_f.ioctl_wr       = wr & ~sel;
  assign bus_f.ioctl_index    = idx;
  assign bus_f.ioctl_addr     = addr;
  assign bus_f.ioctl_dout     = dout;
  assign bus_s.ioctl_download = dl & sel;
  assign bus_s.ioctl_wr       = wr & sel;
  assign bus_s.ioctl_index    = idx;
  assign bus_s.ioctl_addr     = addr;
  assign bus_s.ioctl_dout     = dout;

  bjk_rom_loader u_full (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .bus        (bus_f),
    .rom_ready  (rom_ready_f),
    .load_error (load_error_f),
    .core_reset (core_reset_f),
    .checksum   (checksum_f)
  );

  bjk_rom_loader #(.RomSize(SmallSize)) u_small (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .bus        (bus_s),
    .rom_ready  (rom_ready_s),
    .load_error (load_error_s),
    .core_reset (core_reset_s),
    .checksum   (checksum_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Small-instance scoreboard: every dn_wr must match the next issued address.
  logic [24:0] exp_q[$];
  logic [24:0] mon_e;
  int pulses_s = 0;
  int viol_s   = 0;

  always @(negedge clk_sys) begin
    if (bus_s.dn_wr) begin
      pulses_s++;
      if (exp_q.size() == 0) begin
        viol_s++;
      end else begin
        mon_e = exp_q.pop_front();
        if (bus_s.dn_region !== 6'b000001 || bus_s.dn_addr !== mon_e[16:0] ||
            bus_s.dn_data !== mon_e[7:0]) viol_s++;
      end
    end else if (bus_s.dn_region !== 6'b000000) begin
      viol_s++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_sys);
    #1;
  endtask

  // Sequential index-0 load on the small instance, data = addr[7:0].
  task automatic load_small(input int n, input bit fall_with_last, input bit extra_ovf);
    dl  = 1'b1;
    idx = 8'd0;
    tick(1);
    for (int i = 0; i < n; i++) begin
      addr = 25'(i);
      dout = i[7:0];
      wr   = 1'b1;
      exp_q.push_back(addr);
      if (fall_with_last && !extra_ovf && i == n - 1) dl = 1'b0;
      tick(1);
    end
    if (extra_ovf) begin
      addr = 25'(SmallSize);
      dout = 8'hEE;
      wr   = 1'b1;
      tick(1);
    end
    wr = 1'b0;
    dl = 1'b0;
  endtask

  // Outcome one and two cycles after download falls.
  task automatic expect_end(input string name, input bit already_fallen, input bit ok);
    if (!already_fallen) tick(1);
    settle();
    chk({name, "_check_not_ready"}, 32'(rom_ready_s), 32'd0);
    tick(1);
    settle();
    chk({name, "_rom_ready"},  32'(rom_ready_s),  32'(ok));
    chk({name, "_core_reset"}, 32'(core_reset_s), 32'(!ok));
    chk({name, "_load_error"}, 32'(load_error_s), 32'(!ok));
  endtask

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic        wr;
    logic [5:0]  region;
    logic [16:0] off;
  } vec_t;

  vec_t vecs[15];
  logic [15:0] sum_f;
  int p0;

  initial begin
    vecs[0]  = '{25'h0000000, 8'h11, 1'b1, 6'b000001, 17'h00000};
    vecs[1]  = '{25'h0009FFF, 8'h22, 1'b1, 6'b000001, 17'h09FFF};
    vecs[2]  = '{25'h000A000, 8'h33, 1'b1, 6'b000010, 17'h00000};
    vecs[3]  = '{25'h000BFFF, 8'h44, 1'b1, 6'b000010, 17'h01FFF};
    vecs[4]  = '{25'h000C000, 8'h55, 1'b1, 6'b000100, 17'h00000};
    vecs[5]  = '{25'h000EFFF, 8'h66, 1'b1, 6'b000100, 17'h02FFF};
    vecs[6]  = '{25'h000F000, 8'h77, 1'b1, 6'b001000, 17'h00000};
    vecs[7]  = '{25'h0014FFF, 8'h88, 1'b1, 6'b001000, 17'h05FFF};
    vecs[8]  = '{25'h0015000, 8'h99, 1'b1, 6'b010000, 17'h00000};
    vecs[9]  = '{25'h001AFFF, 8'hAA, 1'b1, 6'b010000, 17'h05FFF};
    vecs[10] = '{25'h001B000, 8'hBB, 1'b1, 6'b100000, 17'h00000};
    vecs[11] = '{25'h001BFFF, 8'hCC, 1'b1, 6'b100000, 17'h00FFF};
    vecs[12] = '{25'h001C000, 8'hDD, 1'b0, 6'b000000, 17'h00000};
    vecs[13] = '{25'h001FFFF, 8'hDE, 1'b0, 6'b000000, 17'h00000};
    vecs[14] = '{25'h1000000, 8'hDF, 1'b0, 6'b000000, 17'h00000};

    dl = 0; wr = 0; sel = 0; idx = 0; addr = 0; dout = 0; reset = 1;
    tick(3);
    reset = 0;
    settle();
    chk("rst_rom_ready_f",  32'(rom_ready_f),     32'd0);
    chk("rst_load_error_f", 32'(load_error_f),    32'd0);
    chk("rst_core_reset_f", 32'(core_reset_f),    32'd1);
    chk("rst_checksum_f",   32'(checksum_f),      32'd0);
    chk("rst_dn_wr_f",      32'(bus_f.dn_wr),     32'd0);
    chk("rst_dn_region_s",  32'(bus_s.dn_region), 32'd0);
    chk("rst_core_reset_s", 32'(core_reset_s),    32'd1);

    // Region decode and out-of-range drop on the full-size instance.
    sel = 0;
    tick(1);
    dl  = 1;
    idx = 0;
    tick(1);
    sum_f = 16'h0000;
    foreach (vecs[i]) begin
      addr = vecs[i].addr;
      dout = vecs[i].data;
      wr   = 1;
      tick(1);
      wr = 0;
      settle();
      chk($sformatf("vec%0d_dn_wr", i),     32'(bus_f.dn_wr),     32'(vecs[i].wr));
      chk($sformatf("vec%0d_dn_region", i), 32'(bus_f.dn_region), 32'(vecs[i].region));
      if (vecs[i].wr) begin
        chk($sformatf("vec%0d_dn_addr", i), 32'(bus_f.dn_addr), 32'(vecs[i].off));
        chk($sformatf("vec%0d_dn_data", i), 32'(bus_f.dn_data), 32'(vecs[i].data));
        sum_f = sum_f + {8'd0, vecs[i].data};
      end
      tick(1);
    end
    chk("vec_checksum", 32'(checksum_f), 32'(sum_f));
    dl = 0;
    tick(1);
    settle();
    chk("vec_check_cycle_error", 32'(load_error_f), 32'd0);
    tick(1);
    settle();
    chk("vec_load_error", 32'(load_error_f), 32'd1);
    chk("vec_rom_ready",  32'(rom_ready_f),  32'd0);
    chk("vec_core_reset", 32'(core_reset_f), 32'd1);

    // Back-to-back writes across the cpu/snd boundary.
    tick(1);
    dl = 1;
    tick(1);
    addr = 25'h0009FFF; dout = 8'hA5; wr = 1;
    tick(1);
    addr = 25'h000A000; dout = 8'h5A;
    settle();
    chk("bnd0_dn_wr",     32'(bus_f.dn_wr),     32'd1);
    chk("bnd0_dn_region", 32'(bus_f.dn_region), 32'h01);
    chk("bnd0_dn_addr",   32'(bus_f.dn_addr),   32'h09FFF);
    chk("bnd0_dn_data",   32'(bus_f.dn_data),   32'hA5);
    tick(1);
    wr = 0;
    settle();
    chk("bnd1_dn_wr",     32'(bus_f.dn_wr),     32'd1);
    chk("bnd1_dn_region", 32'(bus_f.dn_region), 32'h02);
    chk("bnd1_dn_addr",   32'(bus_f.dn_addr),   32'h00000);
    chk("bnd1_dn_data",   32'(bus_f.dn_data),   32'h5A);
    tick(1);
    settle();
    chk("bnd2_dn_wr",     32'(bus_f.dn_wr),     32'd0);
    chk("bnd2_dn_region", 32'(bus_f.dn_region), 32'd0);
    dl = 0;
    tick(3);

    // Complete image, last byte in the same cycle download falls.
    sel = 1;
    p0  = pulses_s;
    load_small(int'(SmallSize), 1'b1, 1'b0);
    expect_end("full", 1'b1, 1'b1);
    chk("full_pulses",   32'(pulses_s - p0), 32'(SmallSize));
    chk("full_checksum", 32'(checksum_s),    32'hF800);

    // Non-ROM index download is ignored.
    p0  = pulses_s;
    dl  = 1;
    idx = 8'd3;
    tick(1);
    for (int i = 0; i < 16; i++) begin
      addr = 25'(i); dout = 8'h3C; wr = 1;
      tick(1);
    end
    wr = 0; dl = 0; idx = 0;
    tick(3);
    settle();
    chk("idx3_pulses",     32'(pulses_s - p0), 32'd0);
    chk("idx3_rom_ready",  32'(rom_ready_s),   32'd1);
    chk("idx3_core_reset", 32'(core_reset_s),  32'd0);
    chk("idx3_checksum",   32'(checksum_s),    32'hF800);

    // One byte short.
    p0 = pulses_s;
    load_small(int'(SmallSize) - 1, 1'b0, 1'b0);
    expect_end("short", 1'b0, 1'b0);
    chk("short_pulses",   32'(pulses_s - p0), 32'(SmallSize) - 32'd1);
    chk("short_checksum", 32'(checksum_s),    32'hF701);

    // Complete image plus one write past the end.
    p0 = pulses_s;
    load_small(int'(SmallSize), 1'b0, 1'b1);
    expect_end("ovf", 1'b0, 1'b0);
    chk("ovf_pulses", 32'(pulses_s - p0), 32'(SmallSize));

    // Reset in the middle of a load, download still open.
    p0 = pulses_s;
    dl = 1;
    tick(1);
    for (int i = 0; i < 'h500; i++) begin
      addr = 25'(i); dout = i[7:0]; wr = 1;
      exp_q.push_back(addr);
      tick(1);
    end
    wr    = 0;
    reset = 1;
    tick(1);
    reset = 0;
    settle();
    chk("rstmid_pulses",     32'(pulses_s - p0), 32'h500);
    chk("rstmid_core_reset", 32'(core_reset_s),  32'd1);
    chk("rstmid_rom_ready",  32'(rom_ready_s),   32'd0);
    chk("rstmid_checksum",   32'(checksum_s),    32'd0);
    chk("rstmid_dn_wr",      32'(bus_s.dn_wr),   32'd0);
    dl = 0;
    tick(3);
    settle();
    chk("rstmid_idle_no_error", 32'(load_error_s), 32'd0);
    p0 = pulses_s;
    load_small(int'(SmallSize), 1'b1, 1'b0);
    expect_end("reload", 1'b1, 1'b1);
    chk("reload_pulses",   32'(pulses_s - p0), 32'(SmallSize));
    chk("reload_checksum", 32'(checksum_s),    32'hF800);

    tick(2);
    settle();
    chk("scoreboard_violations", 32'(viol_s),       32'd0);
    chk("scoreboard_drained",    32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
